// File: rtl/mem_wait_responder.sv
// Word-addressed data memory with fixed read/write wait states.
// Holds the pipeline via a combinational stall while an access is in flight.
module mem_wait_responder #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH_LOG = 10,
    parameter int unsigned WAIT_RD   = 2,
    parameter int unsigned WAIT_WR   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              ren,
    input  logic              wen,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              stall,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(WAIT_RD - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WAIT_WR - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic                   op_wr, op_wr_d;
    logic [DEPTH_LOG-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]      din_q, din_d;
    logic                   err_d;
    logic                   stall_c;
    logic                   do_acc;
    logic                   acc_wr;
    logic [DEPTH_LOG-1:0]   acc_idx;
    logic [DATA_W-1:0]      acc_data;
    logic                   req;
    logic                   aligned;
    logic [DEPTH_LOG-1:0]   req_idx;
    logic                   addr_unused;

    logic [DATA_W-1:0]      mem [DEPTH];

    assign req         = cs & (ren | wen);
    assign aligned     = (addr[1:0] == 2'b00);
    assign req_idx     = addr[DEPTH_LOG+1:2];
    // Upper address bits alias onto the array and are deliberately ignored.
    assign addr_unused = ^addr[31:DEPTH_LOG+2];

    // Next-state, counter and access-strobe logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        op_wr_d  = op_wr;
        idx_d    = idx_q;
        din_d    = din_q;
        err_d    = 1'b0;
        stall_c  = 1'b0;
        do_acc   = 1'b0;
        acc_wr   = op_wr;
        acc_idx  = idx_q;
        acc_data = din_q;

        case (state)
            IDLE: begin
                if (req) begin
                    err_d = ~aligned | (ren & wen);
                    if (aligned) begin
                        stall_c = 1'b1;
                        op_wr_d = wen;
                        idx_d   = req_idx;
                        din_d   = din;
                        cnt_d   = wen ? WR_LOAD : RD_LOAD;
                        // A single wait state completes at the end of the accept cycle.
                        if (cnt_d == '0) begin
                            do_acc   = 1'b1;
                            acc_wr   = wen;
                            acc_idx  = req_idx;
                            acc_data = din;
                            state_d  = DONE;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                cnt_d   = cnt - CNT_W'(1);
                if (cnt_d == '0) begin
                    do_acc  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall must fall the moment reset asserts, even with a request still present.
    assign stall = rst_n & stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_wr <= 1'b0;
            idx_q <= '0;
            din_q <= '0;
            dout  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            op_wr <= op_wr_d;
            idx_q <= idx_d;
            din_q <= din_d;
            err   <= err_d;
            if (do_acc && !acc_wr) begin
                dout <= mem[acc_idx];
            end
        end
    end

    // Array storage is not reset.
    always_ff @(posedge clk) begin
        if (do_acc && acc_wr) begin
            mem[acc_idx] <= acc_data;
        end
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed self-checking bench for mem_wait_responder: latency, errors, aliasing, reset abort.
module tb_mem_wait_responder;

    logic        clk;
    logic        rst_n, rst_n_b;
    logic        cs, ren, wen;
    logic [31:0] addr, din, dout;
    logic        stall, err;
    logic        cs_b, ren_b, wen_b;
    logic [31:0] addr_b, din_b, dout_b;
    logic        stall_b, err_b;

    int vectors = 0;
    int errors  = 0;
    int n;

    mem_wait_responder #(.DATA_W(32), .DEPTH_LOG(10), .WAIT_RD(2), .WAIT_WR(1)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .ren(ren), .wen(wen),
        .addr(addr), .din(din), .dout(dout), .stall(stall), .err(err)
    );

    mem_wait_responder #(.DATA_W(32), .DEPTH_LOG(10), .WAIT_RD(2), .WAIT_WR(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .cs(cs_b), .ren(ren_b), .wen(wen_b),
        .addr(addr_b), .din(din_b), .dout(dout_b), .stall(stall_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        cs = 1'b1; wen = w; ren = r; addr = a; din = d;
    endtask

    task automatic idle();
        tick();
        cs = 1'b0; ren = 1'b0; wen = 1'b0;
    endtask

    // Counts stall cycles on the main instance, returning at the first non-stall negedge.
    task automatic wait_done(output int cnt);
        bit done;
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stall) cnt++;
            else done = 1'b1;
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL wait_done: stall still high after 20 cycles, required low");
        end
    endtask

    task automatic wait_done_b(output int cnt);
        bit done;
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stall_b) cnt++;
            else done = 1'b1;
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL wait_done_b: stall still high after 20 cycles, required low");
        end
    endtask

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0;
        cs = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; din = '0;
        cs_b = 1'b0; ren_b = 1'b0; wen_b = 1'b0; addr_b = '0; din_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_err",   32'(err),   32'd0);
        check("reset_dout",  dout,       32'h0);
        tick();
        rst_n = 1'b1; rst_n_b = 1'b1;

        // Preload then read with 2 wait states
        start(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        wait_done(n);
        check("wr10_stall_cycles", 32'(n), 32'd1);
        check("wr_keeps_dout", dout, 32'h0);
        idle();
        start(1'b0, 1'b1, 32'h10, 32'h0);
        wait_done(n);
        check("rd10_stall_cycles", 32'(n), 32'd2);
        check("rd10_dout", dout, 32'hDEADBEEF);
        check("rd10_err", 32'(err), 32'd0);
        idle();

        // Write then read back
        start(1'b1, 1'b0, 32'h20, 32'h12345678);
        wait_done(n);
        check("wr20_stall_cycles", 32'(n), 32'd1);
        idle();
        start(1'b0, 1'b1, 32'h20, 32'h0);
        wait_done(n);
        check("rd20_stall_cycles", 32'(n), 32'd2);
        check("rd20_dout", dout, 32'h12345678);
        idle();

        // Misaligned read: error pulse, no stall, dout unchanged
        start(1'b0, 1'b1, 32'h22, 32'h0);
        wait_done(n);
        check("mis_stall_cycles", 32'(n), 32'd0);
        idle();
        @(negedge clk);
        check("mis_err_pulse", 32'(err), 32'd1);
        check("mis_dout_hold", dout, 32'h12345678);
        @(negedge clk);
        check("mis_err_clear", 32'(err), 32'd0);
        tick();

        // ren & wen together: write wins, err pulses
        start(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
        wait_done(n);
        check("both_stall_cycles", 32'(n), 32'd1);
        check("both_err_pulse", 32'(err), 32'd1);
        idle();
        @(negedge clk);
        check("both_err_clear", 32'(err), 32'd0);
        tick();
        start(1'b0, 1'b1, 32'h30, 32'h0);
        wait_done(n);
        check("rd30_dout", dout, 32'hA5A5A5A5);
        idle();

        // Back-to-back reads with cs held high
        start(1'b1, 1'b0, 32'h0, 32'h11111111);
        wait_done(n);
        idle();
        start(1'b1, 1'b0, 32'h4, 32'h22222222);
        wait_done(n);
        idle();
        start(1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk); check("b2b_stall0", 32'(stall), 32'd1);
        tick();
        @(negedge clk); check("b2b_stall1", 32'(stall), 32'd1);
        tick();
        addr = 32'h4;
        @(negedge clk); check("b2b_stall2", 32'(stall), 32'd0);
        check("b2b_dout0", dout, 32'h11111111);
        tick();
        @(negedge clk); check("b2b_stall3", 32'(stall), 32'd1);
        tick();
        @(negedge clk); check("b2b_stall4", 32'(stall), 32'd1);
        tick();
        @(negedge clk); check("b2b_stall5", 32'(stall), 32'd0);
        check("b2b_dout1", dout, 32'h22222222);
        idle();
        @(negedge clk); check("b2b_dout_hold", dout, 32'h22222222);
        tick();

        // Aliasing: 0x1000 maps onto word 0
        start(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D);
        wait_done(n);
        idle();
        start(1'b0, 1'b1, 32'h0, 32'h0);
        wait_done(n);
        check("alias_dout", dout, 32'hCAFEF00D);
        idle();

        // Second instance (3 write wait states): preload and read
        cs_b = 1'b1; wen_b = 1'b1; addr_b = 32'h40; din_b = 32'h0BADF00D;
        wait_done_b(n);
        check("b_wr_stall_cycles", 32'(n), 32'd3);
        tick();
        wen_b = 1'b0; ren_b = 1'b1;
        wait_done_b(n);
        check("b_rd_dout", dout_b, 32'h0BADF00D);
        tick();

        // Reset on the 2nd stall cycle of a write aborts it
        ren_b = 1'b0; wen_b = 1'b1; din_b = 32'hFFFFFFFF;
        @(negedge clk); check("b_abort_stall1", 32'(stall_b), 32'd1);
        tick();
        check("b_abort_stall2", 32'(stall_b), 32'd1);
        #2;
        rst_n_b = 1'b0;
        #1;
        check("b_async_stall_drop", 32'(stall_b), 32'd0);
        check("b_reset_dout", dout_b, 32'h0);
        tick();
        cs_b = 1'b0; wen_b = 1'b0;
        tick();
        rst_n_b = 1'b1;
        tick();
        cs_b = 1'b1; ren_b = 1'b1;
        wait_done_b(n);
        check("b_rd_after_abort", dout_b, 32'h0BADF00D);
        tick();
        cs_b = 1'b0; ren_b = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
